pipeline_ifetch: RTL

- Instruction-fetch responder side of the PC register. Consumes the current PC and issues word fetches to instruction memory over a req/ack handshake.
- Fills the IF/ID pipeline register and returns PCWrite to the PC unit, so the PC only advances when an instruction has been committed.
- Handles ID stalls, with a one-entry hold buffer, and redirect flushes that occur while a fetch is outstanding.

---
 rtl/pipeline_ifetch.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_ifetch.sv
// Instruction-fetch responder: issues word fetches for the current PC and fills IF/ID.
// Define IFETCH_ALIGN_CHK_EN to trap misaligned PCs into a FAULT state instead of fetching.
module pipeline_ifetch #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC,
  input  logic        flush,
  input  logic        id_stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        PCWrite,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_valid,
  output logic        IF_ID_fault
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
`ifdef IFETCH_ALIGN_CHK_EN
    DROP,
    FAULT
`else
    DROP
`endif
  } state_t;

  state_t      state, state_n;
  logic [31:0] ifid_instr, instr_n;
  logic [31:0] ifid_pc, pc_n;
  logic        ifid_valid, valid_n;
  logic [31:0] hold_instr, hinstr_n;
  logic [31:0] hold_pc, hpc_n;
  logic [31:2] addr_q, addr_n;
  logic        pcwrite;
  logic        misaligned;

`ifdef IFETCH_ALIGN_CHK_EN
  logic fault_q, fault_n;
  assign misaligned  = |PC[1:0];
  assign IF_ID_fault = fault_q;
`else
  assign misaligned  = 1'b0;
  assign IF_ID_fault = 1'b0;
`endif

  // DROP keeps presenting the abandoned address until the memory acks it.
  assign imem_req  = ((state == REQ) && !misaligned) || (state == DROP);
  assign imem_addr = (state == DROP) ? {addr_q, 2'b00} : {PC[31:2], 2'b00};

  assign PCWrite           = pcwrite;
  assign IF_ID_Instruction = ifid_instr;
  assign IF_ID_PC          = ifid_pc;
  assign IF_ID_valid       = ifid_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= RESET_PC;
      ifid_valid <= 1'b0;
      hold_instr <= NOP_INSTR;
      hold_pc    <= RESET_PC;
      addr_q     <= RESET_PC[31:2];
`ifdef IFETCH_ALIGN_CHK_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      ifid_instr <= instr_n;
      ifid_pc    <= pc_n;
      ifid_valid <= valid_n;
      hold_instr <= hinstr_n;
      hold_pc    <= hpc_n;
      addr_q     <= addr_n;
`ifdef IFETCH_ALIGN_CHK_EN
      fault_q    <= fault_n;
`endif
    end
  end

  always_comb begin
    state_n  = state;
    instr_n  = ifid_instr;
    pc_n     = ifid_pc;
    valid_n  = ifid_valid;
    hinstr_n = hold_instr;
    hpc_n    = hold_pc;
    addr_n   = addr_q;
    pcwrite  = 1'b0;
`ifdef IFETCH_ALIGN_CHK_EN
    fault_n  = fault_q;
`endif
    unique case (state)
      IDLE: begin
        state_n = REQ;
`ifdef IFETCH_ALIGN_CHK_EN
        if (misaligned) begin
          state_n = FAULT;
          instr_n = NOP_INSTR;
          pc_n    = PC;
          valid_n = 1'b1;
          fault_n = 1'b1;
        end
`endif
      end
      REQ: begin
        addr_n = PC[31:2];
        if (flush) begin
          pcwrite = 1'b1;
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          state_n = (imem_req && !imem_ack) ? DROP : REQ;
`ifdef IFETCH_ALIGN_CHK_EN
        end else if (misaligned) begin
          state_n = FAULT;
          instr_n = NOP_INSTR;
          pc_n    = PC;
          valid_n = 1'b1;
          fault_n = 1'b1;
`endif
        end else if (imem_ack) begin
          if (id_stall) begin
            hinstr_n = imem_rdata;
            hpc_n    = PC;
            state_n  = HOLD;
          end else begin
            instr_n = imem_rdata;
            pc_n    = PC;
            valid_n = 1'b1;
            pcwrite = 1'b1;
          end
        end else if (!id_stall) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
        end
      end
      HOLD: begin
        if (flush) begin
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          pcwrite = 1'b1;
          state_n = REQ;
        end else if (!id_stall) begin
          instr_n = hold_instr;
          pc_n    = hold_pc;
          valid_n = 1'b1;
          pcwrite = 1'b1;
          state_n = REQ;
        end
      end
      DROP: begin
        pcwrite = flush;
        if (imem_ack) state_n = REQ;
      end
`ifdef IFETCH_ALIGN_CHK_EN
      FAULT: begin
        if (flush) begin
          fault_n = 1'b0;
          valid_n = 1'b0;
          instr_n = NOP_INSTR;
          pcwrite = 1'b1;
          state_n = REQ;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

endmodule
